// File: rtl/slow_to_fast_capture.sv
// Captures a fast_clk-registered slow_clk's result on each falling edge of slow_clk into a show-ahead FIFO.
// Optional build macro S2F_DEDUP_EN: drop a capture whose value repeats the previous fall's value.
module slow_to_fast_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    fast_clk,
  input  logic                    rst_n,
  input  logic                    slow_clk,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    en,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic                  slow_d_q;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic fall, push_req, pop, full, push_acc, drop;

  // slow_clk comes from a fast_clk-registered divider, so it is safe to treat as data
  assign fall = slow_d_q & ~slow_clk & en;

`ifdef S2F_DEDUP_EN
  logic [DATA_WIDTH-1:0] last_val_q;
  logic                  last_vld_q;

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val_q <= '0;
      last_vld_q <= 1'b0;
    end else if (fall) begin
      last_val_q <= in_data;
      last_vld_q <= 1'b1;
    end
  end

  assign push_req = fall & (~last_vld_q | (in_data != last_val_q));
`else
  assign push_req = fall;
`endif

  assign level     = wr_ptr_q - rd_ptr_q;
  assign out_valid = (level != '0);
  assign full      = (level == FULL_LVL);
  assign pop       = out_valid & out_ready;
  // a pop in the same cycle frees the slot the push needs
  assign push_acc  = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_d_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      slow_d_q   <= slow_clk;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // storage is cleared so out_data is never X, even while out_valid is low
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_slow_to_fast_capture.sv
// Scoreboard bench for slow_to_fast_capture: a ratio-4 divider drives slow_clk, a queue model predicts every output.
`timescale 1ns/1ps
module tb_slow_to_fast_capture;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 8;

  logic          fast_clk = 1'b0;
  logic          rst_n, slow_clk, en, out_ready, out_valid, overflow;
  logic [DW-1:0] in_data, out_data;
  logic [2:0]    level;
  logic [CW-1:0] drop_cnt;

  always #5 fast_clk = ~fast_clk;

  slow_to_fast_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .fast_clk (fast_clk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .in_data  (in_data),
    .en       (en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] exp_q[$];
  int   div_cnt;
  logic prev_slow;
  bit   auto_en;
  int   m_falls, m_drops, valid_cycles;
  logic m_ovf;
  logic [DW-1:0] m_last_val;
  logic m_last_vld;

  task automatic model_reset();
    exp_q.delete();
    stim_q.delete();
    m_drops = 0;
    m_ovf = 1'b0;
    m_last_val = '0;
    m_last_vld = 1'b0;
    prev_slow = 1'b0;
    div_cnt = 0;
    slow_clk = 1'b0;
  endtask

  // one fast cycle: compare outputs with the model, predict this edge, advance the divider
  task automatic cycle();
    logic fall, preq, pop, full;
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL out_valid got %b want %b at %0t", out_valid, exp_q.size() != 0, $time);
    end
    checks++;
    if (level !== 3'(exp_q.size())) begin
      errors++; $display("FAIL level got %0d want %0d at %0t", level, exp_q.size(), $time);
    end
    checks++;
    if (overflow !== m_ovf || drop_cnt !== 8'(m_drops)) begin
      errors++; $display("FAIL drop_state got ovf=%b cnt=%0d want ovf=%b cnt=%0d at %0t",
                         overflow, drop_cnt, m_ovf, m_drops, $time);
    end
    pop = out_ready && (exp_q.size() != 0);
    if (pop) begin
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++; $display("FAIL out_data got %0d want %0d at %0t", out_data, exp_q[0], $time);
      end
    end
    if (out_valid === 1'b1) valid_cycles++;
    fall = prev_slow && !slow_clk && en;
    preq = fall;
`ifdef S2F_DEDUP_EN
    if (fall) begin
      preq = !m_last_vld || (in_data != m_last_val);
      m_last_val = in_data;
      m_last_vld = 1'b1;
    end
`endif
    if (fall) m_falls++;
    full = (exp_q.size() == DEPTH);
    if (pop) void'(exp_q.pop_front());
    if (preq && full && !pop) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end else if (preq) begin
      exp_q.push_back(in_data);
    end
    prev_slow = slow_clk;
    @(posedge fast_clk);
    #1;
    div_cnt = (div_cnt + 1) % 4;
    if (div_cnt == 2) begin
      slow_clk = 1'b1;
      if (stim_q.size() != 0) begin
        in_data = stim_q.pop_front();
        if (auto_en) en = 1'b1;
      end else if (auto_en) begin
        en = 1'b0;
      end
    end else if (div_cnt == 0) begin
      slow_clk = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; in_data = '0; auto_en = 1'b1;
    m_falls = 0; valid_cycles = 0;
    model_reset();
    repeat (3) @(posedge fast_clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_fifo got level=%0d valid=%b want 0 0", level, out_valid);
    end
    checks++;
    if (out_data !== 8'd0) begin
      errors++; $display("FAIL reset_out_data got %h want 00", out_data);
    end
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_drop got ovf=%b cnt=%0d want 0 0", overflow, drop_cnt);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    valid_cycles = 0;
    stim_q = {8'd1, 8'd2, 8'd3};
    run(20);
    checks++;
    if (valid_cycles != 3) begin
      errors++; $display("FAIL basic_valid_cycles got %0d want 3", valid_cycles);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL basic_overflow got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    stim_q = {8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    run(32);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL overflow_state got level=%0d ovf=%b cnt=%0d want 4 1 2", level, overflow, drop_cnt);
    end
    out_ready = 1'b1;
    run(8);
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL overflow_drain got level=%0d want 0", level);
    end
  endtask

  task automatic test_full_pop();
    int f0;
    out_ready = 1'b0;
    f0 = m_falls;
    stim_q = {8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
    for (int i = 0; i < 40 && m_falls < f0 + 4; i++) cycle();
    for (int i = 0; i < 8 && !(prev_slow && !slow_clk && en); i++) cycle();
    checks++;
    if (!(prev_slow && !slow_clk && en) || level !== 3'd4) begin
      errors++; $display("FAIL full_pop_setup got level=%0d want 4 with fall pending", level);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL full_pop_accept got level=%0d cnt=%0d want 4 2", level, drop_cnt);
    end
    out_ready = 1'b1;
    run(12);
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL full_pop_drain got level=%0d want 0", level);
    end
  endtask

  task automatic test_en_low();
    int f0;
    auto_en = 1'b0;
    en = 1'b0;
    out_ready = 1'b1;
    valid_cycles = 0;
    stim_q = {8'd30, 8'd31, 8'd32};
    run(14);
    checks++;
    if (level !== 3'd0 || valid_cycles != 0) begin
      errors++; $display("FAIL en_low_ignored got level=%0d valid_cycles=%0d want 0 0", level, valid_cycles);
    end
    f0 = m_falls;
    en = 1'b1;
    for (int i = 0; i < 8 && m_falls == f0; i++) cycle();
    en = 1'b0;
    run(4);
    checks++;
    if (valid_cycles != 1) begin
      errors++; $display("FAIL en_high_capture got valid_cycles=%0d want 1", valid_cycles);
    end
    auto_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int f0;
    out_ready = 1'b0;
    f0 = m_falls;
    stim_q = {8'd40, 8'd41, 8'd42};
    for (int i = 0; i < 30 && m_falls < f0 + 3; i++) cycle();
    cycle();
    checks++;
    if (level !== 3'd3) begin
      errors++; $display("FAIL reset_mid_fill got level=%0d want 3", level);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async got level=%0d valid=%b cnt=%0d ovf=%b want 0 0 0 0",
                         level, out_valid, drop_cnt, overflow);
    end
    model_reset();
    en = 1'b0;
    repeat (2) @(posedge fast_clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    valid_cycles = 0;
    stim_q = {8'd50};
    run(12);
    checks++;
    if (valid_cycles != 1) begin
      errors++; $display("FAIL reset_mid_first got valid_cycles=%0d want 1", valid_cycles);
    end
  endtask

  task automatic test_dedup();
    int want;
`ifdef S2F_DEDUP_EN
    want = 3;
`else
    want = 6;
`endif
    out_ready = 1'b1;
    valid_cycles = 0;
    stim_q = {8'd5, 8'd5, 8'd5, 8'd7, 8'd7, 8'd5};
    run(32);
    checks++;
    if (valid_cycles != want) begin
      errors++; $display("FAIL dedup_words got %0d want %0d", valid_cycles, want);
    end
    checks++;
    if (drop_cnt !== 8'd0 || level !== 3'd0) begin
      errors++; $display("FAIL dedup_state got cnt=%0d level=%0d want 0 0", drop_cnt, level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_en_low();
    test_reset_mid();
    test_dedup();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
